uart_cmd_ctrl: RTL and testbench

//  Byte-stream UART command controller for the badge. It sits between the uart_top RX/TX byte

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_ctrl_if.sv | 24 ++
 rtl/uart_cmd_ctrl_led_pwm_chan.sv | 11 +
 rtl/uart_cmd_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state type and command decode helper for the UART command controller.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_LED  = 8'h41;  // 'A'
    localparam logic [7:0] CMD_DUTY = 8'h42;  // 'B'
    localparam logic [7:0] CMD_RESP = 8'h40;  // '@'
    localparam logic [7:0] LED_CLR  = 8'h60;  // '`'
    localparam logic [7:0] CH_BASE  = 8'h41;  // 'A' addresses channel 0

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EXEC,
        RESP
    } state_t;

    function automatic logic is_cmd_byte(input logic [7:0] b);
        return (b == CMD_LED) || (b == CMD_DUTY) || (b == CMD_RESP);
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level bus between the UART (rx strobe, tx handshake) and the command controller.
interface uart_cmd_ctrl_if #(
    parameter int RESP_BYTES = 18
) ();
    // rx: rx_valid is a 1-cycle strobe with no back-pressure.
    // tx: a byte transfers on a cycle with tx_valid & tx_ready; once raised, tx_valid and
    //     tx_data hold steady until that transfer happens.
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [RESP_BYTES*8-1:0] resp_data;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output rx_data, rx_valid, resp_data, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, resp_data, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/uart_cmd_ctrl_led_pwm_chan.sv
// One LED channel: lit while enabled and the shared PWM counter is below this channel's duty.
module led_pwm_chan #(
    parameter int PWM_BITS = 4
) (
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                en_i,
    output logic                led_o
);
    assign led_o = en_i & (pwm_cnt_i < duty_i);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: collects cmd/payload/cmd frames, drives PWM LEDs, streams responses.
// Optional inter-byte timeout in COLLECT is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int FRAME_BYTES    = 18,
    parameter int N_CH           = 8,
    parameter int PWM_BITS       = 4,
    parameter int RESP_BYTES     = 18,
    parameter int TIMEOUT_CYCLES = 10_334_000
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_cmd_ctrl_if.slave      bus,
    output logic [N_CH-1:0]     led_out,
    output logic                frame_err,
    output logic                busy,
    output state_t              dbg_state
);
    localparam int CNT_W = $clog2(FRAME_BYTES);
    localparam int RC_W  = $clog2(RESP_BYTES + 1);
    localparam int SR_W  = RESP_BYTES * 8;

    state_t                             state_q, state_d;
    logic [7:0]                         cmd_q, p0_q, p1_q;
    logic [CNT_W-1:0]                   byte_cnt_q;
    logic [N_CH-1:0]                    led_en_q;
    logic [N_CH-1:0][PWM_BITS-1:0]      duty_q;
    logic [SR_W-1:0]                    resp_sr_q;
    logic [RC_W-1:0]                    resp_cnt_q;
    logic                               frame_err_q;
    logic [PWM_BITS-1:0]                pwm_cnt_q;
    logic                               tx_valid;
    logic                               last_byte, tx_accept, resp_last;
    logic [7:0]                         ch_idx;

    assign last_byte = (byte_cnt_q == CNT_W'(FRAME_BYTES - 1));
    assign tx_accept = tx_valid & bus.tx_ready;
    assign resp_last = (resp_cnt_q == RC_W'(RESP_BYTES - 1));
    // Bytes below CH_BASE wrap to large values and fall outside the channel range.
    assign ch_idx    = p0_q - CH_BASE;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != COLLECT || bus.rx_valid || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.rx_valid && is_cmd_byte(bus.rx_data)) state_d = COLLECT;
            COLLECT: begin
                if (bus.rx_valid && last_byte) state_d = (bus.rx_data == cmd_q) ? EXEC : IDLE;
`ifdef UART_CMD_TIMEOUT_EN
                else if (!bus.rx_valid && tmo_hit) state_d = IDLE;
`endif
            end
            EXEC:    state_d = (cmd_q == CMD_RESP) ? RESP : IDLE;
            RESP:    if (tx_accept && resp_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        tx_valid = (state_q == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            byte_cnt_q  <= '0;
            led_en_q    <= '0;
            duty_q      <= '1;
            resp_sr_q   <= '0;
            resp_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            pwm_cnt_q   <= '0;
        end else begin
            frame_err_q <= 1'b0;
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
            unique case (state_q)
                IDLE: if (bus.rx_valid && is_cmd_byte(bus.rx_data)) begin
                    cmd_q      <= bus.rx_data;
                    byte_cnt_q <= CNT_W'(1);
                end
                COLLECT: begin
                    if (bus.rx_valid) begin
                        if (byte_cnt_q == CNT_W'(1)) p0_q <= bus.rx_data;
                        if (byte_cnt_q == CNT_W'(2)) p1_q <= bus.rx_data;
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        if (last_byte && bus.rx_data != cmd_q) frame_err_q <= 1'b1;
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (tmo_hit) frame_err_q <= 1'b1;
`endif
                end
                EXEC: begin
                    unique case (cmd_q)
                        CMD_LED: begin
                            for (int i = 0; i < N_CH; i++)
                                if (ch_idx == 8'(i)) led_en_q[i] <= 1'b1;
                            if (p0_q == LED_CLR) led_en_q <= '0;
                        end
                        CMD_DUTY: begin
                            for (int i = 0; i < N_CH; i++)
                                if (ch_idx == 8'(i)) duty_q[i] <= p1_q[PWM_BITS-1:0];
                        end
                        CMD_RESP: begin
                            resp_sr_q  <= bus.resp_data;
                            resp_cnt_q <= '0;
                        end
                        default: ;
                    endcase
                end
                RESP: if (tx_accept) begin
                    resp_sr_q  <= resp_sr_q << 8;
                    resp_cnt_q <= resp_cnt_q + RC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = resp_sr_q[SR_W-1 -: 8];
    assign frame_err    = frame_err_q;
    assign dbg_state    = state_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        led_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .duty_i    (duty_q[g]),
            .pwm_cnt_i (pwm_cnt_q),
            .en_i      (led_en_q[g]),
            .led_o     (led_out[g])
        );
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: tx bytes checked through an expected-byte queue and monitor.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int FRAME_BYTES    = 4;
    localparam int N_CH           = 8;
    localparam int PWM_BITS       = 4;
    localparam int RESP_BYTES     = 2;
    localparam int TIMEOUT_CYCLES = 50;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N_CH-1:0] led_out;
    logic            frame_err, busy;
    state_t          dbg_state;

    uart_cmd_ctrl_if #(.RESP_BYTES(RESP_BYTES)) bus ();

    uart_cmd_ctrl #(
        .FRAME_BYTES(FRAME_BYTES), .N_CH(N_CH), .PWM_BITS(PWM_BITS),
        .RESP_BYTES(RESP_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .led_out(led_out), .frame_err(frame_err), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts frame_err cycles and scores every accepted tx byte.
    always @(negedge clk) begin
        if (reset_n && frame_err) ferr_cnt++;
        if (reset_n && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0h expected no byte", bus.tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", 32'(bus.tx_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    // High cycles of channel ch, and cycles where any other channel is high, over one PWM period.
    task automatic measure(input int ch, output int hi, output int other);
        logic [N_CH-1:0] mask;
        mask     = '0;
        mask[ch] = 1'b1;
        hi       = 0;
        other    = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_out[ch]) hi++;
            if ((led_out & ~mask) != '0) other++;
        end
        tick(1);
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int hi, oth, f0, n;
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        bus.resp_data = '0;
        bus.tx_ready  = 1'b0;
        tick(3);
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_led_out", 32'(led_out), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        tick(2);

        // Enable channel 'C' (2) at full duty, then clear all enables.
        send_frame(8'h41, 8'h43, 8'h00, 8'h41);
        check("exec_busy", 32'(busy), 1);
        tick(1);
        check("exec_done_busy", 32'(busy), 0);
        measure(2, hi, oth);
        check("led_en_c_hi", hi, 15);
        check("led_en_c_other", oth, 0);
        send_frame(8'h41, 8'h60, 8'h00, 8'h41);
        tick(2);
        measure(2, hi, oth);
        check("led_clr_hi", hi, 0);
        check("led_clr_other", oth, 0);

        // Duty programming on channel 2.
        send_frame(8'h41, 8'h43, 8'h00, 8'h41);
        tick(2);
        send_frame(8'h42, 8'h43, 8'h04, 8'h42);
        tick(2);
        measure(2, hi, oth);
        check("duty4_hi", hi, 4);
        check("duty4_other", oth, 0);
        send_frame(8'h42, 8'h43, 8'h00, 8'h42);
        tick(2);
        measure(2, hi, oth);
        check("duty0_hi", hi, 0);
        send_frame(8'h42, 8'h43, 8'hA8, 8'h42);
        tick(2);
        measure(2, hi, oth);
        check("duty8_hi", hi, 8);

        // Bad trailer, out-of-range channel, non-command byte in IDLE.
        f0 = ferr_cnt;
        send_frame(8'h41, 8'h43, 8'h00, 8'h42);
        tick(3);
        check("bad_trailer_ferr", ferr_cnt - f0, 1);
        check("bad_trailer_busy", 32'(busy), 0);
        measure(2, hi, oth);
        check("bad_trailer_led", hi, 8);
        f0 = ferr_cnt;
        send_frame(8'h41, 8'h5A, 8'h00, 8'h41);
        tick(2);
        send_frame(8'h42, 8'h5A, 8'h01, 8'h42);
        tick(2);
        check("chan_z_ferr", ferr_cnt - f0, 0);
        measure(2, hi, oth);
        check("chan_z_hi", hi, 8);
        check("chan_z_other", oth, 0);
        send_byte(8'h55);
        check("junk_idle_busy", 32'(busy), 0);

        // Response frame with a stalled transmitter and rx traffic during RESP.
        bus.resp_data = 16'h6869;
        exp_q.push_back(8'h68);
        exp_q.push_back(8'h69);
        send_frame(8'h40, 8'h00, 8'h00, 8'h40);
        check("resp_latency_lo", 32'(bus.tx_valid), 0);
        tick(1);
        check("resp_latency_hi", 32'(bus.tx_valid), 1);
        check("resp_first_byte", 32'(bus.tx_data), 32'h68);
        send_frame(8'h41, 8'h44, 8'h00, 8'h41);
        check("stall_tx_valid", 32'(bus.tx_valid), 1);
        check("stall_tx_data", 32'(bus.tx_data), 32'h68);
        bus.tx_ready = 1'b1;
        n = 0;
        while (bus.tx_valid && n < 10) begin
            tick(1);
            n++;
        end
        bus.tx_ready = 1'b0;
        check("resp_accepts", n, 2);
        check("resp_queue_drained", exp_q.size(), 0);
        check("resp_done_busy", 32'(busy), 0);
        measure(3, hi, oth);
        check("resp_rx_ignored_hi", hi, 0);
        check("resp_rx_ignored_other", oth, 8);

        // Stalled frame: timeout build aborts it, default build waits for the rest.
        f0 = ferr_cnt;
        send_byte(8'h41);
        send_byte(8'h45);
        tick(60);
`ifdef UART_CMD_TIMEOUT_EN
        check("timeout_ferr", ferr_cnt - f0, 1);
        check("timeout_busy", 32'(busy), 0);
        measure(4, hi, oth);
        check("timeout_led_e", hi, 0);
`else
        check("no_timeout_ferr", ferr_cnt - f0, 0);
        check("no_timeout_busy", 32'(busy), 1);
        send_byte(8'h00);
        send_byte(8'h41);
        tick(2);
        check("late_frame_busy", 32'(busy), 0);
        measure(4, hi, oth);
        check("late_frame_led_e", hi, 15);
`endif

        // Asynchronous reset mid-response and mid-frame.
        bus.resp_data = 16'hA55A;
        send_frame(8'h40, 8'h00, 8'h00, 8'h40);
        tick(1);
        check("pre_rst_tx_valid", 32'(bus.tx_valid), 1);
        reset_n = 1'b0;
        #1;
        check("rst_resp_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_resp_busy", 32'(busy), 0);
        check("rst_resp_led", 32'(led_out), 0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        send_byte(8'h41);
        send_byte(8'h43);
        check("pre_rst_collect_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("rst_collect_busy", 32'(busy), 0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        send_frame(8'h41, 8'h42, 8'h00, 8'h41);
        tick(2);
        measure(1, hi, oth);
        check("post_rst_led_b", hi, 15);
        check("post_rst_other", oth, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
